// File: rtl/bu_writeback_if.sv
// Bus bundle between the butterfly datapath and the bank write-back stage.
// The slave side is the write-back block; the master side drives operands and collects writes.
interface bu_writeback_if #(
    parameter int DATA_WIDTH = 13,
    parameter int ADDR_WIDTH = 4
);
    localparam int LW = DATA_WIDTH - 1;

    // start_i/rd_valid_i are single-cycle qualifiers with no back-pressure: the
    // write-back side never stalls, and a beat offered outside RUN is simply dropped.
    logic                  start_i;
    logic [7:0]            len_i;
    logic                  is_NTT_i;
    logic                  rd_valid_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [8*LW-1:0]       a_ntt_i;
    logic [8*LW-1:0]       b_ntt_i;
    logic [8*LW-1:0]       a_intt_i;
    logic [8*LW-1:0]       b_intt_i;
    logic [15:0]           wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [16*LW-1:0]      wr_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic [1:0]            state_dbg_o;

    modport slave (
        input  start_i, len_i, is_NTT_i, rd_valid_i, rd_addr_i,
        input  a_ntt_i, b_ntt_i, a_intt_i, b_intt_i,
        output wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, state_dbg_o
    );

    modport master (
        output start_i, len_i, is_NTT_i, rd_valid_i, rd_addr_i,
        output a_ntt_i, b_ntt_i, a_intt_i, b_intt_i,
        input  wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, state_dbg_o
    );
endinterface

// File: rtl/bu_writeback.sv
// Butterfly result write-back: delays operand beats to line up with BU results and
// scatters the eight A/B result pairs onto the 16 coefficient banks for one NTT stage.
module bu_writeback #(
    parameter int DATA_WIDTH = 13,
    parameter int ADDR_WIDTH = 4,
    parameter int BU_LAT     = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    bu_writeback_if.slave bus
);
    localparam int         LW    = DATA_WIDTH - 1;
    localparam logic [4:0] BEATS = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_q, len_d;
    logic                  ntt_q, ntt_d;
    logic [4:0]            beat_cnt_q, beat_cnt_d;
    logic [4:0]            wr_cnt_q, wr_cnt_d;
    logic [BU_LAT-1:0]     vld_dly_q, vld_dly_d;
    logic [ADDR_WIDTH-1:0] addr_dly_q [BU_LAT];
    logic [ADDR_WIDTH-1:0] addr_dly_d [BU_LAT];
    logic [15:0]           wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [16*LW-1:0]      wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  wr_beat;
    logic                  len_ok;
    logic [2:0]            bu;
    logic [3:0]            dst_a, dst_b;
    logic [8*LW-1:0]       src_a, src_b;
    logic [16*LW-1:0]      routed;

    assign accept  = (state_q == RUN) && bus.rd_valid_i && (beat_cnt_q < BEATS);
    assign wr_beat = vld_dly_q[BU_LAT-1];
    assign src_a   = ntt_q ? bus.a_ntt_i : bus.a_intt_i;
    assign src_b   = ntt_q ? bus.b_ntt_i : bus.b_intt_i;

    always_comb begin
        case (len_q)
            8'd128, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2: len_ok = 1'b1;
            default:                                       len_ok = 1'b0;
        endcase
    end

    // Destination lane = {B-bank half, bank index}; each stage length is a bit
    // permutation of the BU number, with BU0/BU1 special-cased for the short stages.
    always_comb begin
        routed = '0;
        bu     = 3'd0;
        dst_a  = 4'd0;
        dst_b  = 4'd0;
        for (int k = 0; k < 8; k++) begin
            bu = 3'(k);
            case (len_q)
                8'd128: begin
                    dst_a = {bu[2], bu[1:0], 1'b0};
                    dst_b = {bu[2], bu[1:0], 1'b1};
                end
                8'd64: begin
                    dst_a = {bu[1], bu[2], bu[0], 1'b0};
                    dst_b = {bu[1], bu[2], bu[0], 1'b1};
                end
                8'd32: begin
                    dst_a = {bu[0], bu[2], bu[1], 1'b0};
                    dst_b = {bu[0], bu[2], bu[1], 1'b1};
                end
                8'd16, 8'd8, 8'd4, 8'd2: begin
                    if (bu[2:1] == 2'b00) begin
                        dst_a = {3'b000, bu[0]};
                        dst_b = {3'b100, bu[0]};
                    end else begin
                        dst_a = {bu[0], bu[2], bu[1], 1'b0};
                        dst_b = {bu[0], bu[2], bu[1], 1'b1};
                    end
                end
                default: begin
                    dst_a = 4'd0;
                    dst_b = 4'd0;
                end
            endcase
            if (len_ok) begin
                routed[int'(dst_a)*LW +: LW] = src_a[k*LW +: LW];
                routed[int'(dst_b)*LW +: LW] = src_b[k*LW +: LW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        ntt_d      = ntt_q;
        beat_cnt_d = beat_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        done_d     = 1'b0;
        wr_en_d    = 16'h0000;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        vld_dly_d[0]  = accept;
        addr_dly_d[0] = bus.rd_addr_i;
        for (int k = 1; k < BU_LAT; k++) begin
            vld_dly_d[k]  = vld_dly_q[k-1];
            addr_dly_d[k] = addr_dly_q[k-1];
        end

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d    = RUN;
                    len_d      = bus.len_i;
                    ntt_d      = bus.is_NTT_i;
                    beat_cnt_d = 5'd0;
                    wr_cnt_d   = 5'd0;
                end
            end
            RUN: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    if (beat_cnt_d == BEATS) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_cnt_q == BEATS) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An unsupported length still walks the beats through, just with no bank enabled.
        if (wr_beat && (wr_cnt_q < BEATS)) begin
            wr_cnt_d  = wr_cnt_q + 5'd1;
            wr_en_d   = len_ok ? 16'hFFFF : 16'h0000;
            wr_addr_d = addr_dly_q[BU_LAT-1];
            wr_data_d = routed;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            len_q      <= 8'd0;
            ntt_q      <= 1'b0;
            beat_cnt_q <= 5'd0;
            wr_cnt_q   <= 5'd0;
            vld_dly_q  <= '0;
            for (int k = 0; k < BU_LAT; k++) addr_dly_q[k] <= '0;
            wr_en_q    <= 16'h0000;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ntt_q      <= ntt_d;
            beat_cnt_q <= beat_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            vld_dly_q  <= vld_dly_d;
            for (int k = 0; k < BU_LAT; k++) addr_dly_q[k] <= addr_dly_d[k];
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.state_dbg_o = state_q;
endmodule
